// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch target buffer with 2-bit counters and stats
module branch_predictor #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        predict,
    output logic [31:0] predict_pc,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = 31 - IDX_W;

    logic             valid_q  [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic             unused_upd_pc0;

    assign rd_idx = pc[IDX_W:1];
    assign rd_tag = pc[31:IDX_W+1];
    assign wr_idx = upd_pc[IDX_W:1];
    assign wr_tag = upd_pc[31:IDX_W+1];
    assign unused_upd_pc0 = upd_pc[0];

    // Lookup reads the registered table, so a same-cycle update is only seen next cycle.
    assign rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign predict    = rd_hit && ctr_q[rd_idx][1];
    assign predict_pc = rd_hit ? target_q[rd_idx] : pc + 32'd4;

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (upd_en) begin
            if (stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (upd_mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
                stat_mispredicts <= stat_mispredicts + 32'd1;

            if (wr_hit) begin
                if (upd_taken && (ctr_q[wr_idx] != 2'b11))
                    ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'b01;
                else if (!upd_taken && (ctr_q[wr_idx] != 2'b00))
                    ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'b01;
            end else if (upd_taken) begin
                valid_q[wr_idx] <= 1'b1;
                ctr_q[wr_idx]   <= 2'b10;
            end
        end
    end

    // Tags and targets carry no reset; the valid bits alone decide whether they matter.
    always_ff @(posedge clk) begin
        if (!rst && upd_en && upd_taken) begin
            target_q[wr_idx] <= upd_target;
            if (!wr_hit)
                tag_q[wr_idx] <= wr_tag;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and random checks of branch_predictor against a table model
module tb_branch_predictor;

    localparam int IDX_W = 4;
    localparam int DEPTH = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        predict;
    logic [31:0] predict_pc;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_mispredict = 1'b0;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .pc(pc), .predict(predict), .predict_pc(predict_pc),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    // Model: a plain array of entries addressed by (pc / 2) mod DEPTH, tag = pc / (2*DEPTH).
    bit          m_valid [DEPTH];
    longint      m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    longint      m_br = 0;
    longint      m_mis = 0;
    bit          chk_en = 0;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 2) % DEPTH);
    endfunction

    function automatic longint tag_of(input logic [31:0] a);
        return longint'(a) / (2 * DEPTH);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] = 0;
                m_ctr[i] = 0;
            end
            m_br = 0;
            m_mis = 0;
            chk_en = 1;
        end else if (upd_en) begin
            int i;
            i = idx_of(upd_pc);
            m_br = (m_br < 64'hFFFF_FFFF) ? m_br + 1 : m_br;
            if (upd_mispredict) m_mis = (m_mis < 64'hFFFF_FFFF) ? m_mis + 1 : m_mis;
            if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1;
                m_tag[i] = tag_of(upd_pc);
                m_tgt[i] = upd_target;
                m_ctr[i] = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int i;
            bit hit;
            logic exp_pred;
            i = idx_of(pc);
            hit = m_valid[i] && (m_tag[i] == tag_of(pc));
            exp_pred = hit && (m_ctr[i] >= 2);
            checks++;
            if (predict !== exp_pred) begin
                errors++;
                $display("FAIL model_predict pc=%h got %b expected %b", pc, predict, exp_pred);
            end
            if (!hit || exp_pred) begin
                logic [31:0] exp_pc;
                exp_pc = hit ? m_tgt[i] : pc + 32'd4;
                checks++;
                if (predict_pc !== exp_pc) begin
                    errors++;
                    $display("FAIL model_predict_pc pc=%h got %h expected %h", pc, predict_pc, exp_pc);
                end
            end
            checks++;
            if (stat_branches !== m_br[31:0] || stat_mispredicts !== m_mis[31:0]) begin
                errors++;
                $display("FAIL model_stats got %0d/%0d expected %0d/%0d",
                         stat_branches, stat_mispredicts, m_br, m_mis);
            end
        end
    end

    task automatic step(input logic r, input logic [31:0] p, input logic en,
                        input logic [31:0] up, input logic tk, input logic [31:0] tg,
                        input logic mis);
        @(posedge clk);
        #1;
        rst = r; pc = p; upd_en = en; upd_pc = up;
        upd_taken = tk; upd_target = tg; upd_mispredict = mis;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic look(input logic [31:0] p);
        step(0, p, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic upd(input logic [31:0] p, input logic [31:0] up, input logic tk,
                       input logic [31:0] tg);
        step(0, p, 1, up, tk, tg, 0);
    endtask

    initial begin
        step(1, 32'h3000, 0, 32'h0, 0, 32'h0, 0);
        step(1, 32'h3000, 0, 32'h0, 0, 32'h0, 0);
        chk("rst_predict", {31'd0, predict}, 32'd0);
        chk("rst_predict_pc", predict_pc, 32'h3004);
        look(32'h3000);
        chk("idle_predict", {31'd0, predict}, 32'd0);
        chk("idle_predict_pc", predict_pc, 32'h3004);
        chk("idle_branches", stat_branches, 32'd0);
        chk("idle_mispredicts", stat_mispredicts, 32'd0);

        upd(32'h3000, 32'h3010, 1, 32'h3000);
        look(32'h3010);
        chk("alloc_predict", {31'd0, predict}, 32'd1);
        chk("alloc_predict_pc", predict_pc, 32'h3000);

        // Each lookup shows the counter value before that cycle's update.
        upd(32'h3010, 32'h3010, 0, 32'h0);
        chk("ctr10_pred", {31'd0, predict}, 32'd1);
        upd(32'h3010, 32'h3010, 0, 32'h0);
        chk("ctr01_pred", {31'd0, predict}, 32'd0);
        upd(32'h3010, 32'h3010, 1, 32'h3100);
        chk("ctr00_pred", {31'd0, predict}, 32'd0);
        upd(32'h3010, 32'h3010, 1, 32'h3100);
        chk("ctr01b_pred", {31'd0, predict}, 32'd0);
        upd(32'h3010, 32'h3010, 1, 32'h3200);
        chk("ctr10b_pred", {31'd0, predict}, 32'd1);
        chk("ctr10b_target", predict_pc, 32'h3100);
        upd(32'h3010, 32'h3010, 1, 32'h3200);
        chk("ctr11_pred", {31'd0, predict}, 32'd1);
        upd(32'h3010, 32'h3010, 0, 32'h0);
        chk("ctr11_sat_pred", {31'd0, predict}, 32'd1);
        look(32'h3010);
        chk("ctr_after_sat_pred", {31'd0, predict}, 32'd1);
        chk("ctr_after_sat_target", predict_pc, 32'h3200);

        upd(32'h3010, 32'h3030, 1, 32'h3500);
        look(32'h3010);
        chk("alias_old_pred", {31'd0, predict}, 32'd0);
        chk("alias_old_pc", predict_pc, 32'h3014);
        look(32'h3030);
        chk("alias_new_pred", {31'd0, predict}, 32'd1);
        chk("alias_new_pc", predict_pc, 32'h3500);

        upd(32'h3020, 32'h3020, 1, 32'h3600);
        chk("same_cycle_pred", {31'd0, predict}, 32'd0);
        chk("same_cycle_pc", predict_pc, 32'h3024);
        look(32'h3020);
        chk("next_cycle_pred", {31'd0, predict}, 32'd1);
        chk("next_cycle_pc", predict_pc, 32'h3600);

        upd(32'h3040, 32'h3040, 0, 32'h3700);
        look(32'h3040);
        chk("nt_miss_noalloc", {31'd0, predict}, 32'd0);
        look(32'h3020);
        chk("nt_miss_keeps_occupant", predict_pc, 32'h3600);

        step(1, 32'h3000, 0, 32'h0, 0, 32'h0, 0);
        for (int n = 0; n < 10; n++)
            step(0, 32'h3000, 1, 32'h3000 + 32'(n) * 2, 1, 32'h4000, (n % 3) == 1);
        look(32'h3000);
        chk("stats_branches", stat_branches, 32'd10);
        chk("stats_mispredicts", stat_mispredicts, 32'd3);
        step(1, 32'h3002, 1, 32'h3050, 1, 32'h4400, 1);
        look(32'h3050);
        chk("rst_drop_pred", {31'd0, predict}, 32'd0);
        chk("rst_drop_pc", predict_pc, 32'h3054);
        chk("rst_drop_branches", stat_branches, 32'd0);
        chk("rst_drop_mispredicts", stat_mispredicts, 32'd0);
        look(32'h3002);
        chk("rst_empty_pred", {31'd0, predict}, 32'd0);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] a, b;
            a = 32'h3000 + 32'($urandom_range(0, 7)) * 32'h10 + 32'($urandom_range(0, 1)) * 2
                + 32'($urandom_range(0, 1));
            b = 32'h3000 + 32'($urandom_range(0, 7)) * 32'h10 + 32'($urandom_range(0, 1)) * 2;
            step($urandom_range(0, 63) == 0, a, 1'($urandom_range(0, 1)), b,
                 1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
- REQ-001 Parameter IDX_W, default 4, index width; table depth = 2^IDX_W entries.
- REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
- REQ-003 Port rst  input  1  reset; synchronous and active-high.
- REQ-004 Port pc  input  32  current fetch PC (halfword aligned; pc[0] ignored).
- REQ-005 Port predict  output  1  predict taken for the instruction at pc.
- REQ-006 Port predict_pc  output  32  predicted target; meaningful only when predict=1.
- REQ-007 Port upd_en  input  1  EX resolved a branch or jump this cycle.
- REQ-008 Port upd_pc  input  32  PC of the resolved instruction.
- REQ-009 Port upd_taken  input  1  resolved direction.
- REQ-010 Port upd_target  input  32  resolved target address.
- REQ-011 Port upd_mispredict  input  1  EX flushed because of this instruction (qualified by upd_en).
- REQ-012 Port stat_branches  output  32  count of accepted updates.
- REQ-013 Port stat_mispredicts  output  32  count of accepted updates with upd_mispredict=1.

Function
- REQ-014 Table entry SHALL hold valid (1b), tag = pc[31:IDX_W+1], target (32b) and a 2-bit saturating counter.
- REQ-015 Index SHALL be pc[IDX_W:1] for lookup and upd_pc[IDX_W:1] for update.
- REQ-016 Lookup SHALL be combinational, zero latency: hit = valid & tag match; predict = hit & counter[1]; predict_pc = entry target.
- REQ-017 On miss, predict SHALL be 0 and predict_pc SHALL be pc + 4.
- REQ-018 Update SHALL be written at the rising edge when upd_en=1; no write when upd_en=0.
- REQ-019 Update hit, upd_taken=1: counter saturating increment (max 2'b11); target <= upd_target.
- REQ-020 Update hit, upd_taken=0: counter saturating decrement (min 2'b00); target unchanged; entry remains valid.
- REQ-021 Update miss, upd_taken=1: allocate (replace any occupant): valid=1, tag from upd_pc, target=upd_target, counter=2'b10.
- REQ-022 Update miss, upd_taken=0: no allocation; table unchanged.
- REQ-023 Lookup and update to the same index in the same cycle: lookup SHALL return pre-update contents; new contents visible the next cycle.
- REQ-024 Only the addressed entry SHALL change on an update.
- REQ-025 stat_branches SHALL increment by 1 per upd_en cycle; stat_mispredicts by 1 when upd_en & upd_mispredict; both saturate at 32'hFFFF_FFFF.
- REQ-026 No stall input: updates are accepted every cycle; back-to-back updates to the same entry SHALL each apply in order.

Reset
- REQ-027 While rst=1 at a clock edge, all valid bits, counters and stat registers SHALL clear to 0; targets and tags need not be cleared.
- REQ-028 Reset SHALL take priority over a simultaneous update; that update is dropped.
- REQ-029 During and after reset, until first allocation, predict SHALL be 0 and predict_pc = pc + 4.

Verification
- REQ-030 Reset, then pc=32'h3000 -> predict=0, predict_pc=32'h3004, stats=0.
- REQ-031 Update upd_pc=32'h3010, taken, target=32'h3000; next cycle pc=32'h3010 -> predict=1, predict_pc=32'h3000.
- REQ-032 Same entry: two not-taken updates -> counter 10->01->00, predict=0; three taken updates -> 01,10,11 with predict=1 from counter 10; fourth taken keeps 11.
- REQ-033 Alias: allocate 32'h3010, then taken update at 32'h3030 (same index at IDX_W=4, different tag) -> pc=32'h3010 misses, pc=32'h3030 hits with the new target.
- REQ-034 Same-cycle pc=upd_pc=32'h3020 with taken update on an empty entry -> predict=0 that cycle, predict=1 next cycle.
- REQ-035 Ten upd_en cycles, three with upd_mispredict=1, then rst asserted alongside an update -> stats read 10/3 before reset, 0/0 and table empty after.
